wb_arbiter2: RTL and testbench

Two-master to one-slave Wishbone (pipelined) arbiter on the SoC data path, between requesters and `memory_wrapper`. Master 0 is the core data port. Master 1 is a secondary requester, such as a debug loader or DMA. The arbiter grants whole bus tenures (one `cyc` assertion), with round-robin or fixed priority. It tracks outstanding transfers so slave acks return to the owning master, and it bounds the pipeline depth.

---
 rtl/wb_arbiter2.sv | 154 +++++++++++++++
 tb/tb_wb_arbiter2.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter2.sv
// Two-master to one-slave pipelined Wishbone arbiter. It grants whole cyc tenures and
// caps the number of accepted-but-unacked transfers at MAX_OUTSTANDING.
//
// state    | meaning
// ST_IDLE  | no owner; slave side quiet, requesters stalled
// ST_OWN0  | master 0 owns the slave until it drops cyc
// ST_OWN1  | master 1 owns the slave until it drops cyc
module wb_arbiter2 #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int ROUND_ROBIN     = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_wb_cyc,
    input  logic        m0_wb_stb,
    input  logic        m0_wb_wr_en,
    input  logic [31:0] m0_wb_addr,
    input  logic [31:0] m0_wb_wr_data,
    input  logic [3:0]  m0_wb_wr_sel,
    output logic        m0_wb_ack,
    output logic        m0_wb_stall,
    output logic [31:0] m0_wb_rd_data,

    input  logic        m1_wb_cyc,
    input  logic        m1_wb_stb,
    input  logic        m1_wb_wr_en,
    input  logic [31:0] m1_wb_addr,
    input  logic [31:0] m1_wb_wr_data,
    input  logic [3:0]  m1_wb_wr_sel,
    output logic        m1_wb_ack,
    output logic        m1_wb_stall,
    output logic [31:0] m1_wb_rd_data,

    output logic        s_wb_cyc,
    output logic        s_wb_stb,
    output logic        s_wb_wr_en,
    output logic [31:0] s_wb_addr,
    output logic [31:0] s_wb_wr_data,
    output logic [3:0]  s_wb_wr_sel,
    input  logic        s_wb_ack,
    input  logic        s_wb_stall,
    input  logic [31:0] s_wb_rd_data
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    logic [1:0]       state, state_nxt;
    logic             last, last_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             full;
    logic             accept;
    logic             retire;

    assign full   = (cnt == CNT_MAX);
    assign accept = s_wb_stb & ~s_wb_stall;
    // an ack with nothing outstanding must not wrap the counter
    assign retire = s_wb_ack & (cnt != '0);

    assign m0_wb_rd_data = s_wb_rd_data;
    assign m1_wb_rd_data = s_wb_rd_data;

    always_comb begin
        s_wb_cyc     = 1'b0;
        s_wb_stb     = 1'b0;
        s_wb_wr_en   = 1'b0;
        s_wb_addr    = '0;
        s_wb_wr_data = '0;
        s_wb_wr_sel  = '0;
        m0_wb_ack    = 1'b0;
        m1_wb_ack    = 1'b0;
        m0_wb_stall  = m0_wb_cyc;
        m1_wb_stall  = m1_wb_cyc;
        if (state == ST_OWN0) begin
            s_wb_cyc     = m0_wb_cyc;
            s_wb_stb     = m0_wb_stb & ~full;
            s_wb_wr_en   = m0_wb_wr_en;
            s_wb_addr    = m0_wb_addr;
            s_wb_wr_data = m0_wb_wr_data;
            s_wb_wr_sel  = m0_wb_wr_sel;
            m0_wb_stall  = s_wb_stall | full;
            m0_wb_ack    = s_wb_ack;
        end else if (state == ST_OWN1) begin
            s_wb_cyc     = m1_wb_cyc;
            s_wb_stb     = m1_wb_stb & ~full;
            s_wb_wr_en   = m1_wb_wr_en;
            s_wb_addr    = m1_wb_addr;
            s_wb_wr_data = m1_wb_wr_data;
            s_wb_wr_sel  = m1_wb_wr_sel;
            m1_wb_stall  = s_wb_stall | full;
            m1_wb_ack    = s_wb_ack;
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        cnt_nxt   = cnt;
        if (accept && !retire) begin
            cnt_nxt = cnt + CNT_ONE;
        end else if (retire && !accept) begin
            cnt_nxt = cnt - CNT_ONE;
        end
        case (state)
            ST_IDLE: begin
                if (m0_wb_cyc && m1_wb_cyc) begin
                    // last resets to 1 so m0 wins the first contention
                    state_nxt = (ROUND_ROBIN != 0 && !last) ? ST_OWN1 : ST_OWN0;
                end else if (m0_wb_cyc) begin
                    state_nxt = ST_OWN0;
                end else if (m1_wb_cyc) begin
                    state_nxt = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!m0_wb_cyc) begin
                    state_nxt = ST_IDLE;
                    last_nxt  = 1'b0;
                    cnt_nxt   = '0;
                end
            end
            ST_OWN1: begin
                if (!m1_wb_cyc) begin
                    state_nxt = ST_IDLE;
                    last_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: a round-robin MAX=4 instance and a fixed-priority MAX=2 instance
// share all inputs and are each compared every cycle against a tenure/count model.
module tb_wb_arbiter2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  cyc, stb, we;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [3:0]  sel [2];
    logic        s_ack, s_stall;
    logic [31:0] s_rdata;

    logic [1:0]             o_scyc, o_sstb, o_swe;
    logic [1:0][31:0]       o_saddr, o_swdata;
    logic [1:0][3:0]        o_ssel;
    logic [1:0][1:0]        o_mack, o_mstall;
    logic [1:0][1:0][31:0]  o_mrd;

    logic [1:0]             snap_scyc, snap_sstb;
    logic [1:0][31:0]       snap_saddr, snap_swdata;
    logic [1:0][3:0]        snap_ssel;
    logic [1:0][1:0]        snap_mack, snap_mstall;

    wb_arbiter2 #(.MAX_OUTSTANDING(4), .ROUND_ROBIN(1)) u_a (
        .clk(clk), .rst(rst),
        .m0_wb_cyc(cyc[0]), .m0_wb_stb(stb[0]), .m0_wb_wr_en(we[0]), .m0_wb_addr(addr[0]),
        .m0_wb_wr_data(wdata[0]), .m0_wb_wr_sel(sel[0]), .m0_wb_ack(o_mack[0][0]),
        .m0_wb_stall(o_mstall[0][0]), .m0_wb_rd_data(o_mrd[0][0]),
        .m1_wb_cyc(cyc[1]), .m1_wb_stb(stb[1]), .m1_wb_wr_en(we[1]), .m1_wb_addr(addr[1]),
        .m1_wb_wr_data(wdata[1]), .m1_wb_wr_sel(sel[1]), .m1_wb_ack(o_mack[0][1]),
        .m1_wb_stall(o_mstall[0][1]), .m1_wb_rd_data(o_mrd[0][1]),
        .s_wb_cyc(o_scyc[0]), .s_wb_stb(o_sstb[0]), .s_wb_wr_en(o_swe[0]), .s_wb_addr(o_saddr[0]),
        .s_wb_wr_data(o_swdata[0]), .s_wb_wr_sel(o_ssel[0]), .s_wb_ack(s_ack),
        .s_wb_stall(s_stall), .s_wb_rd_data(s_rdata)
    );

    wb_arbiter2 #(.MAX_OUTSTANDING(2), .ROUND_ROBIN(0)) u_b (
        .clk(clk), .rst(rst),
        .m0_wb_cyc(cyc[0]), .m0_wb_stb(stb[0]), .m0_wb_wr_en(we[0]), .m0_wb_addr(addr[0]),
        .m0_wb_wr_data(wdata[0]), .m0_wb_wr_sel(sel[0]), .m0_wb_ack(o_mack[1][0]),
        .m0_wb_stall(o_mstall[1][0]), .m0_wb_rd_data(o_mrd[1][0]),
        .m1_wb_cyc(cyc[1]), .m1_wb_stb(stb[1]), .m1_wb_wr_en(we[1]), .m1_wb_addr(addr[1]),
        .m1_wb_wr_data(wdata[1]), .m1_wb_wr_sel(sel[1]), .m1_wb_ack(o_mack[1][1]),
        .m1_wb_stall(o_mstall[1][1]), .m1_wb_rd_data(o_mrd[1][1]),
        .s_wb_cyc(o_scyc[1]), .s_wb_stb(o_sstb[1]), .s_wb_wr_en(o_swe[1]), .s_wb_addr(o_saddr[1]),
        .s_wb_wr_data(o_swdata[1]), .s_wb_wr_sel(o_ssel[1]), .s_wb_ack(s_ack),
        .s_wb_stall(s_stall), .s_wb_rd_data(s_rdata)
    );

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    // reference model: owner (-1 = nobody), previous owner, outstanding transfers
    int own [2];
    int last [2];
    int outst [2];
    int maxo [2];
    int rrm [2];
    int g_own [2];
    logic g_acc [2];
    logic [1:0] g_ack [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            logic full;
            int o;
            logic e_scyc, e_sstb, e_swe;
            logic [31:0] e_addr, e_wd;
            logic [3:0] e_sel;
            logic [1:0] e_ack, e_stall;
            full    = (outst[d] == maxo[d]);
            o       = own[d];
            e_scyc  = 1'b0; e_sstb = 1'b0; e_swe = 1'b0;
            e_addr  = '0;   e_wd   = '0;   e_sel = '0;
            e_ack   = 2'b00;
            e_stall = cyc;
            if (o >= 0) begin
                e_scyc     = cyc[o];
                e_sstb     = stb[o] & ~full;
                e_swe      = we[o];
                e_addr     = addr[o];
                e_wd       = wdata[o];
                e_sel      = sel[o];
                e_stall[o] = s_stall | full;
                e_ack[o]   = s_ack;
            end
            chk($sformatf("d%0d s_cyc", d), 32'(o_scyc[d]), 32'(e_scyc));
            chk($sformatf("d%0d s_stb", d), 32'(o_sstb[d]), 32'(e_sstb));
            chk($sformatf("d%0d s_we", d), 32'(o_swe[d]), 32'(e_swe));
            chk($sformatf("d%0d s_addr", d), o_saddr[d], e_addr);
            chk($sformatf("d%0d s_wdata", d), o_swdata[d], e_wd);
            chk($sformatf("d%0d s_sel", d), 32'(o_ssel[d]), 32'(e_sel));
            chk($sformatf("d%0d m_ack", d), 32'(o_mack[d]), 32'(e_ack));
            chk($sformatf("d%0d m_stall", d), 32'(o_mstall[d]), 32'(e_stall));
            chk($sformatf("d%0d m0_rd", d), o_mrd[d][0], s_rdata);
            chk($sformatf("d%0d m1_rd", d), o_mrd[d][1], s_rdata);
            g_own[d] = o;
            g_acc[d] = e_sstb & ~s_stall;
            g_ack[d] = e_ack;
        end
        chk("a cnt", 32'(u_a.cnt), outst[0]);
        chk("b cnt", 32'(u_b.cnt), outst[1]);
    endtask

    task automatic update_model();
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                own[d] = -1; last[d] = 1; outst[d] = 0;
            end else if (own[d] < 0) begin
                if (cyc == 2'b11)  own[d] = (rrm[d] == 1) ? 1 - last[d] : 0;
                else if (cyc[0])   own[d] = 0;
                else if (cyc[1])   own[d] = 1;
            end else if (!cyc[own[d]]) begin
                last[d] = own[d]; own[d] = -1; outst[d] = 0;
            end else begin
                outst[d] = outst[d] + (g_acc[d] ? 1 : 0) - ((s_ack && outst[d] > 0) ? 1 : 0);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
        snap_scyc = o_scyc; snap_sstb = o_sstb; snap_saddr = o_saddr;
        snap_swdata = o_swdata; snap_ssel = o_ssel; snap_mack = o_mack; snap_mstall = o_mstall;
        @(posedge clk);
        update_model();
        #1;
    endtask

    int iss [2];
    int got [2];
    int seq_a [$];
    int seq_b [$];
    int gaps_a [$];
    int gap_a;
    logic prev_a, prev_b;
    int na, nb;

    initial begin
        maxo = '{4, 2}; rrm = '{1, 0};
        own = '{-1, -1}; last = '{1, 1}; outst = '{0, 0};
        g_acc = '{1'b0, 1'b0}; g_ack = '{2'b00, 2'b00};
        rst = 1'b0; cyc = 2'b00; stb = 2'b00; we = 2'b00;
        addr = '{32'h10, 32'h20}; wdata = '{32'h0, 32'h0}; sel = '{4'h0, 4'h0};
        s_ack = 1'b0; s_stall = 1'b0; s_rdata = 32'h0;
        @(posedge clk); #1;

        // reset held with both requesting
        cyc = 2'b11;
        tick(); tick();
        chk("rst s_cyc a", 32'(snap_scyc[0]), 32'd0);
        chk("rst stall a", 32'(snap_mstall[0]), 32'd3);
        chk("rst stall b", 32'(snap_mstall[1]), 32'd3);
        chk("rst ack a", 32'(snap_mack[0]), 32'd0);
        rst = 1'b1;
        tick();
        chk("first grant m0", o_saddr[0], 32'h10);
        chk("first grant cyc", 32'(o_scyc[0]), 32'd1);

        // contention: each tenure does two reads then drops cyc for one cycle
        iss = '{0, 0}; got = '{0, 0};
        gap_a = 0; prev_a = 1'b0; prev_b = 1'b0;
        for (int i = 0; i < 80 && seq_a.size() < 4; i++) begin
            for (int n = 0; n < 2; n++) begin
                if (!cyc[n]) begin
                    cyc[n] = 1'b1; iss[n] = 0; got[n] = 0;
                end else if (got[n] >= 2) begin
                    cyc[n] = 1'b0; stb[n] = 1'b0;
                end else begin
                    stb[n] = (own[0] == n && iss[n] < 2);
                end
            end
            s_ack = g_acc[0];
            s_rdata = $urandom;
            tick();
            for (int n = 0; n < 2; n++) begin
                if (g_own[0] == n && g_acc[0]) iss[n]++;
                if (g_ack[0][n]) got[n]++;
            end
            if (!snap_scyc[0]) gap_a++;
            else begin
                if (!prev_a) begin
                    seq_a.push_back(snap_saddr[0] == 32'h20 ? 1 : 0);
                    gaps_a.push_back(gap_a);
                end
                gap_a = 0;
            end
            if (snap_scyc[1] && !prev_b) seq_b.push_back(snap_saddr[1] == 32'h20 ? 1 : 0);
            prev_a = snap_scyc[0];
            prev_b = snap_scyc[1];
        end
        chk("rr tenures seen", 32'(seq_a.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < seq_a.size(); i++)
            chk($sformatf("rr owner %0d", i), seq_a[i], i % 2);
        // a gap is the owner's drop cycle plus exactly one IDLE cycle
        for (int i = 1; i < 4 && i < gaps_a.size(); i++)
            chk($sformatf("rr gap %0d", i), gaps_a[i], 2);
        chk("fp tenures seen", 32'(seq_b.size() >= 2), 32'd1);
        foreach (seq_b[i]) chk($sformatf("fp owner %0d", i), seq_b[i], 0);

        cyc = 2'b00; stb = 2'b00; s_ack = 1'b0;
        tick(); tick(); tick();

        // outstanding limit: m0 writes every cycle, slave acks late
        cyc = 2'b01; stb = 2'b01; we = 2'b01;
        addr[0] = 32'h10; wdata[0] = 32'hDEADBEEF; sel[0] = 4'hF;
        tick();
        na = 0; nb = 0;
        repeat (7) begin
            tick();
            na += (snap_sstb[0] && !s_stall) ? 1 : 0;
            nb += (snap_sstb[1] && !s_stall) ? 1 : 0;
        end
        chk("limit stbs a", na, 4);
        chk("limit stbs b", nb, 2);
        chk("limit stall b", 32'(snap_mstall[1][0]), 32'd1);
        s_ack = 1'b1;
        tick();
        chk("full+ack blocks b", 32'(snap_sstb[1]), 32'd0);
        chk("full+ack blocks a", 32'(snap_sstb[0]), 32'd0);
        tick();
        chk("acc+ack stb b", 32'(snap_sstb[1]), 32'd1);
        chk("acc+ack cnt b", 32'(u_b.cnt), 32'd1);
        chk("acc+ack cnt a", 32'(u_a.cnt), 32'd3);
        chk("wr addr b", snap_saddr[1], 32'h10);
        chk("wr data b", snap_swdata[1], 32'hDEADBEEF);
        chk("wr sel b", 32'(snap_ssel[1]), 32'hF);
        stb = 2'b00;
        tick();
        chk("drain cnt b", 32'(u_b.cnt), 32'd0);
        s_ack = 1'b0; cyc = 2'b00; we = 2'b00;
        tick();

        // stray ack while idle
        s_ack = 1'b1;
        tick();
        chk("stray ack a", 32'(snap_mack[0]), 32'd0);
        chk("stray ack b", 32'(snap_mack[1]), 32'd0);
        s_ack = 1'b0;

        // reset in the middle of an m1 tenure with three transfers outstanding
        cyc = 2'b10; stb = 2'b10; addr[1] = 32'h20;
        tick();
        repeat (3) tick();
        stb = 2'b00;
        tick();
        chk("pre-rst cnt a", 32'(u_a.cnt), 32'd3);
        rst = 1'b0;
        tick();
        chk("mid-rst cnt a", 32'(u_a.cnt), 32'd0);
        chk("mid-rst s_cyc a", 32'(o_scyc[0]), 32'd0);
        chk("mid-rst s_cyc b", 32'(o_scyc[1]), 32'd0);
        rst = 1'b1;
        tick();

        // random traffic
        repeat (400) begin
            for (int n = 0; n < 2; n++) begin
                if ($urandom_range(7) == 0) cyc[n] = ~cyc[n];
                stb[n]   = 1'($urandom_range(1));
                we[n]    = 1'($urandom_range(1));
                addr[n]  = $urandom;
                wdata[n] = $urandom;
                sel[n]   = 4'($urandom_range(15));
            end
            s_ack   = ($urandom_range(2) == 0);
            s_stall = ($urandom_range(3) == 0);
            s_rdata = $urandom;
            rst     = ($urandom_range(60) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
